z16_button_conditioner: RTL and testbench

//   Input conditioner directly upstream of the Z16 core's button MMIO read (address 0x007C).

---
 rtl/z16_button_conditioner.sv | 114 +++++++++++
 tb/tb_z16_button_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/z16_button_conditioner.sv
// Button conditioner for the Z16 button MMIO read: sync, debounce, strobes, pending, count.
// Ports: i_clk, i_rst_n, i_btn_raw, i_pending_clr -> o_btn_level, o_press/release_pulse, o_press_pending, o_press_count.
module z16_button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int CNT_W           = 19,
  parameter bit RAW_ACTIVE_LOW  = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_btn_raw,
  input  logic       i_pending_clr,
  output logic       o_btn_level,
  output logic       o_press_pulse,
  output logic       o_release_pulse,
  output logic       o_press_pending,
  output logic [7:0] o_press_count
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
      ((DEBOUNCE_CYCLES - 1) >> CNT_W) != 0) begin : g_cfg_err
    $error("z16_button_conditioner: bad SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W");
  end

  typedef enum logic [1:0] {
    UP,
    DOWN_CHK,
    DOWN,
    UP_CHK
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sample;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

  // Reset loads the released pad level so no spurious press follows reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync <= {SYNC_STAGES{RAW_ACTIVE_LOW}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], i_btn_raw};
    end
  end

  assign sample = sync[SYNC_STAGES-1] ^ RAW_ACTIVE_LOW;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= UP;
      cnt             <= '0;
      o_btn_level     <= 1'b0;
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      o_press_pending <= 1'b0;
      o_press_count   <= 8'd0;
    end else begin
      o_press_pulse   <= 1'b0;
      o_release_pulse <= 1'b0;
      // Set is held through the pulse cycle so a clear there cannot drop it.
      o_press_pending <= o_press_pulse |
                         (o_press_pending & ~i_pending_clr);
      unique case (state)
        UP: begin
          if (sample) begin
            state <= DOWN_CHK;
            cnt   <= '0;
          end
        end
        DOWN_CHK: begin
          if (!sample) begin
            state <= UP;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state           <= DOWN;
            cnt             <= '0;
            o_btn_level     <= 1'b1;
            o_press_pulse   <= 1'b1;
            o_press_pending <= 1'b1;
            o_press_count   <= o_press_count + 8'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DOWN: begin
          if (!sample) begin
            state <= UP_CHK;
            cnt   <= '0;
          end
        end
        UP_CHK: begin
          if (sample) begin
            state <= DOWN;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state           <= UP;
            cnt             <= '0;
            o_btn_level     <= 1'b0;
            o_release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_z16_button_conditioner.sv
// Scoreboard bench for z16_button_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2, active-low pad).
// Stimulus pushes expected pulse events; a negedge monitor pops and compares them.
module tb_z16_button_conditioner;

  logic       clk;
  logic       rst_n;
  logic       raw;
  logic       clr;
  logic       level;
  logic       ppulse;
  logic       rpulse;
  logic       pending;
  logic [7:0] count;

  z16_button_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (2),
    .RAW_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_btn_raw      (raw),
    .i_pending_clr  (clr),
    .o_btn_level    (level),
    .o_press_pulse  (ppulse),
    .o_release_pulse(rpulse),
    .o_press_pending(pending),
    .o_press_count  (count)
  );

  typedef struct {
    bit   press;
    int   cyc;
    int   cnt;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  exp_cnt  = 0;
  int  rel_seen = 0;

  // Raw change driven at a negedge is sampled on the next edge;
  // the level flips SYNC_STAGES + DEBOUNCE_CYCLES edges after that.
  localparam int LAT = 7;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)",
               name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && (ppulse || rpulse)) begin
      chk("pulse_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        ev_t e;
        e = exp_q.pop_front();
        chk("pulse_kind", int'(ppulse), int'(e.press));
        chk("pulse_kind_rel", int'(rpulse), int'(!e.press));
        chk("pulse_cycle", cyc, e.cyc);
        chk("level_at_pulse", int'(level), int'(e.press));
        chk("count_at_pulse", int'(count), e.cnt);
        if (e.press) chk("pending_at_press", int'(pending), 1);
      end
      if (rpulse) rel_seen++;
    end
  end

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input bit race);
    ev_t e;
    @(negedge clk);
    raw = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    e.press = 1'b1;
    e.cyc   = cyc + LAT;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
    if (race) begin
      repeat (LAT) @(negedge clk);
      chk("race_pulse_now", int'(ppulse), 1);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      chk("pending_after_race", int'(pending), 1);
    end
    drain();
  endtask

  task automatic release_btn();
    ev_t e;
    @(negedge clk);
    raw = 1'b1;
    e.press = 1'b0;
    e.cyc   = cyc + LAT;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
    drain();
  endtask

  task automatic glitch(input logic v, input int lvl);
    @(negedge clk);
    raw = v;
    repeat (3) @(negedge clk);
    raw = ~v;
    repeat (12) @(negedge clk);
    chk("glitch_level", int'(level), lvl);
    chk("glitch_count", int'(count), exp_cnt);
  endtask

  initial begin
    int r0;
    int m;
    rst_n = 1'b0;
    raw   = 1'b1;
    clr   = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", int'({level, ppulse, rpulse, pending, count}), 0);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (20) @(negedge clk);
    chk("idle_outputs", int'({level, ppulse, rpulse, pending, count}), 0);

    // 2: clean press then release
    press(1'b0);
    chk("press_level", int'(level), 1);
    chk("press_pending", int'(pending), 1);
    chk("press_count", int'(count), 1);
    repeat (30) @(negedge clk);
    chk("hold_no_repeat", int'(count), 1);
    release_btn();
    chk("release_level", int'(level), 0);

    // 3a: low glitch in UP
    glitch(1'b0, 0);

    // 4: clear racing a press, then clear later
    press(1'b1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("pending_cleared", int'(pending), 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clear_when_zero", int'(pending), 0);

    // 3b: high glitch in DOWN
    glitch(1'b1, 1);
    release_btn();

    // 5: 256 press/release pairs wrap the counter
    r0 = rel_seen;
    for (int i = 0; i < 256; i++) begin
      press(1'b0);
      release_btn();
    end
    chk("wrap_count", int'(count), 2);
    chk("wrap_releases", rel_seen - r0, 256);

    // 6: reset two cycles into DOWN_CHK
    @(negedge clk);
    raw = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset_pending", int'(pending), 1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        int'({level, ppulse, rpulse, pending, count}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_cnt = 1;
    m = cyc;
    exp_q.push_back('{press: 1'b1, cyc: m + LAT, cnt: 1});
    drain();
    chk("post_reset_level", int'(level), 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
